fifo_ctrl: RTL and testbench

Synchronous FIFO controller that turns the 128×8 single-port `Memory` block into a streaming FIFO with valid/ready handshakes on both sides. It sits directly in front of the memory, driving its `ren`/`wen`/`addr`/`din` and consuming its registered `dout`. It owns the write and read pointers, the occupancy count, single-port arbitration and a one-entry output register.

---
 rtl/fifo_pkg.sv | 8 +
 rtl/fifo_arb.sv | 22 ++
 rtl/fifo_ctrl.sv | 110 +++++++++++
 tb/tb_fifo_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared parameters and grant encoding for the FIFO controller.
package fifo_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 7;
  localparam int DEPTH  = 128;

  typedef enum logic [1:0] {GNT_NONE, GNT_WR, GNT_RD} gnt_e;
endpackage

// File: rtl/fifo_arb.sv
// Two-requester alternating arbiter for the single memory port.
// The last-grant history bit lives in the parent.
module fifo_arb
  import fifo_pkg::*;
(
  input  logic want_wr,
  input  logic want_rd,
  input  logic last_rd,
  output gnt_e gnt,
  output logic conflict
);

  // On a conflict the side that lost last time wins; otherwise the lone requester wins.
  always_comb begin
    gnt      = GNT_NONE;
    conflict = want_wr && want_rd;
    if (conflict)     gnt = last_rd ? GNT_WR : GNT_RD;
    else if (want_wr) gnt = GNT_WR;
    else if (want_rd) gnt = GNT_RD;
  end

endmodule

// File: rtl/fifo_ctrl.sv
// Streaming FIFO controller in front of a single-port registered-output memory.
// Owns pointers, occupancy, port arbitration and a one-entry output register.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_W = fifo_pkg::DATA_W,
  parameter int ADDR_W = fifo_pkg::ADDR_W,
  parameter int DEPTH  = fifo_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              rd_pend, last_rd;
  logic              active, not_full, want_wr, want_rd, conflict;
  gnt_e              gnt;

  // Requests are suppressed while in reset or flushing so neither port fires.
  assign active   = rst_n && !clr;
  assign not_full = count < DEPTH_C;
  assign want_wr  = active && in_valid && not_full;
  assign want_rd  = active && (count != '0) && !rd_pend && (!out_valid || out_ready);

  fifo_arb u_arb (
    .want_wr  (want_wr),
    .want_rd  (want_rd),
    .last_rd  (last_rd),
    .gnt      (gnt),
    .conflict (conflict)
  );

  // Memory port mux; address idles on the write pointer.
  always_comb begin
    mem_wen  = (gnt == GNT_WR);
    mem_ren  = (gnt == GNT_RD);
    mem_addr = (gnt == GNT_RD) ? rd_ptr : wr_ptr;
    mem_din  = in_data;
    if (!rst_n) begin
      mem_addr = '0;
      mem_din  = '0;
    end
  end

  // in_ready does not look at in_valid through want_wr except via the read grant.
  assign in_ready = active && not_full && (gnt != GNT_RD);
  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0) && !rd_pend && !out_valid;

  // Pointer, occupancy, in-flight read, output register and arbitration history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_pend   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      last_rd   <= 1'b0;
    end else if (clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_pend   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      last_rd   <= 1'b0;
    end else begin
      if (conflict) last_rd <= (gnt == GNT_RD);
      // Memory dout is valid only in the cycle after the read was issued.
      if (rd_pend) begin
        out_data  <= mem_dout;
        out_valid <= 1'b1;
        rd_pend   <= 1'b0;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      case (gnt)
        GNT_WR: begin
          wr_ptr <= wr_ptr + 1'b1;
          count  <= count + 1'b1;
        end
        GNT_RD: begin
          rd_ptr  <= rd_ptr + 1'b1;
          count   <= count - 1'b1;
          rd_pend <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl with a behavioural 128x8 single-port memory.
module tb_fifo_ctrl;
  logic       clk = 1'b0;
  logic       rst_n, clr, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data, out_data, mem_din, mem_dout;
  logic       mem_ren, mem_wen, full, empty;
  logic [6:0] mem_addr;
  logic [7:0] count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_ctrl dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout),
    .count(count), .full(full), .empty(empty)
  );

  // Memory model: registered dout, 0 when not reading; write blocked by read.
  logic [7:0] mem [128];
  always @(posedge clk) begin
    mem_dout <= mem_ren ? mem[mem_addr] : 8'h00;
    if (mem_wen && !mem_ren) mem[mem_addr] <= mem_din;
  end

  // Push one word, waiting a bounded time for in_ready.
  task automatic push(input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = d;
    #1;
    while (!in_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (!in_ready) begin
      errors++; $display("FAIL push_timeout: data %02h never accepted", d);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Pop one word and compare against the expected value.
  task automatic pop(input logic [7:0] exp);
    int n = 0;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    while (!out_valid && n < 20) begin
      @(negedge clk); #1; n++;
    end
    out_ready = 1'b1;
    checks++;
    if (out_data !== exp || out_valid !== 1'b1) begin
      errors++; $display("FAIL pop_data: got %02h valid %b, want %02h", out_data, out_valid, exp);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic do_clr();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #3;
    checks++;
    if (in_ready !== 1'b0 || mem_ren !== 1'b0 || mem_wen !== 1'b0 || empty !== 1'b1 ||
        full !== 1'b0 || mem_addr !== 7'd0 || mem_din !== 8'd0) begin
      errors++; $display("FAIL in_reset: rdy %b ren %b wen %b empty %b full %b addr %0d din %02h, want 0 0 0 1 0 0 00",
                         in_ready, mem_ren, mem_wen, empty, full, mem_addr, mem_din);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || empty !== 1'b1 || count !== 8'd0 || mem_ren !== 1'b0 ||
        mem_wen !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL post_reset: rdy %b empty %b count %0d ren %b wen %b ov %b, want 1 1 0 0 0 0",
                         in_ready, empty, count, mem_ren, mem_wen, out_valid);
    end
  endtask

  task automatic test_single();
    // cycle 0: write to addr 0
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
    #1;
    checks++;
    if (mem_wen !== 1'b1 || mem_ren !== 1'b0 || mem_addr !== 7'd0 || mem_din !== 8'hA5 || in_ready !== 1'b1) begin
      errors++; $display("FAIL single_c0: wen %b ren %b addr %0d din %02h rdy %b, want 1 0 0 a5 1",
                         mem_wen, mem_ren, mem_addr, mem_din, in_ready);
    end
    // cycle 1: read from addr 0
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (mem_ren !== 1'b1 || mem_wen !== 1'b0 || mem_addr !== 7'd0 || count !== 8'd1) begin
      errors++; $display("FAIL single_c1: ren %b wen %b addr %0d count %0d, want 1 0 0 1",
                         mem_ren, mem_wen, mem_addr, count);
    end
    // cycle 2: read in flight
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || empty !== 1'b0 || count !== 8'd0) begin
      errors++; $display("FAIL single_c2: ov %b empty %b count %0d, want 0 0 0", out_valid, empty, count);
    end
    // cycle 3: data presented
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
      errors++; $display("FAIL single_c3: ov %b data %02h, want 1 a5", out_valid, out_data);
    end
    @(negedge clk); #1;
    checks++;
    if (empty !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL single_empty: empty %b ov %b, want 1 0", empty, out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_fill();
    do_clr();
    out_ready = 1'b0;
    // 129 pushes: one lands in the output register, 128 fill the memory
    for (int i = 0; i < 129; i++) push(8'(i));
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'hEE;
    #1;
    checks++;
    if (count !== 8'd128 || full !== 1'b1 || in_ready !== 1'b0 || mem_wen !== 1'b0 || mem_ren !== 1'b0) begin
      errors++; $display("FAIL full: count %0d full %b rdy %b wen %b ren %b, want 128 1 0 0 0",
                         count, full, in_ready, mem_wen, mem_ren);
    end
    in_valid = 1'b0;
    #1;
    // 129 writes from 0 leave the write pointer wrapped to 1
    checks++;
    if (mem_addr !== 7'd1) begin
      errors++; $display("FAIL wr_wrap: idle addr %0d, want 1", mem_addr);
    end
    for (int i = 0; i < 129; i++) pop(8'(i));
    @(negedge clk); #1;
    checks++;
    if (empty !== 1'b1 || count !== 8'd0) begin
      errors++; $display("FAIL fill_drain: empty %b count %0d, want 1 0", empty, count);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] q[$];
    logic [7:0] nxt = 8'h00;
    logic [7:0] held;
    logic       pend_m = 1'b0, last_m = 1'b0, conf, exp_rd;
    int         n_conf = 0, n;
    do_clr();
    for (int c = 0; c < 320; c++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = nxt; out_ready = 1'b1;
      #1;
      checks++;
      if (mem_ren && mem_wen) begin
        errors++; $display("FAIL port_clash: ren %b wen %b in cycle %0d", mem_ren, mem_wen, c);
      end
      conf = (count < 8'd128) && (count != 8'd0) && !pend_m && (!out_valid || out_ready);
      if (conf) begin
        exp_rd = !last_m;
        n_conf++;
        checks++;
        if (mem_ren !== exp_rd || mem_wen !== !exp_rd) begin
          errors++; $display("FAIL alternate: ren %b wen %b, want %b %b", mem_ren, mem_wen, exp_rd, !exp_rd);
        end
        last_m = exp_rd;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0 || out_data !== q[0]) begin
          errors++; $display("FAIL b2b_order: got %02h, want %02h", out_data, (q.size() != 0) ? q[0] : 8'hXX);
        end
        if (q.size() != 0) void'(q.pop_front());
      end
      if (in_ready) begin
        q.push_back(nxt);
        nxt++;
      end
      pend_m = mem_ren;
    end
    checks++;
    if (n_conf < 20) begin
      errors++; $display("FAIL conflict_cov: %0d conflict cycles seen, want >= 20", n_conf);
    end
    // backpressure: output held, no further reads
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    n = 0;
    #1;
    while (!out_valid && n < 10) begin @(negedge clk); #1; n++; end
    held = out_data;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || mem_ren !== 1'b0 || out_data !== held) begin
        errors++; $display("FAIL backpressure: ov %b ren %b data %02h, want 1 0 %02h", out_valid, mem_ren, out_data, held);
      end
    end
    // drain; the writes crossed the 127->0 wrap so order checks cover it
    checks++;
    if (nxt < 8'd140) begin
      errors++; $display("FAIL wrap_cov: only %0d writes, want >= 140", nxt);
    end
    while (q.size() != 0) pop(q.pop_front());
    @(negedge clk); #1;
    checks++;
    if (empty !== 1'b1) begin
      errors++; $display("FAIL b2b_empty: empty %b, want 1", empty);
    end
  endtask

  // Leaves count=5 with a read in flight, positioned just after a negedge + #1.
  task automatic setup_inflight();
    int n = 0;
    do_clr();
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) push(8'h20 + 8'(i));
    @(negedge clk); #1;
    while (!out_valid && n < 10) begin @(negedge clk); #1; n++; end
    out_ready = 1'b1;
    #1;
    checks++;
    if (mem_ren !== 1'b1 || count !== 8'd6) begin
      errors++; $display("FAIL inflight_issue: ren %b count %0d, want 1 6", mem_ren, count);
    end
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    checks++;
    if (count !== 8'd5 || empty !== 1'b0) begin
      errors++; $display("FAIL inflight_state: count %0d empty %b, want 5 0", count, empty);
    end
  endtask

  task automatic test_flush();
    setup_inflight();
    clr = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    checks++;
    if (mem_ren !== 1'b0 || mem_wen !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL clr_gate: ren %b wen %b rdy %b, want 0 0 0", mem_ren, mem_wen, in_ready);
    end
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    checks++;
    if (count !== 8'd0 || out_valid !== 1'b0 || empty !== 1'b1) begin
      errors++; $display("FAIL clr_state: count %0d ov %b empty %b, want 0 0 1", count, out_valid, empty);
    end
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || empty !== 1'b1) begin
      errors++; $display("FAIL clr_discard: ov %b empty %b, want 0 1", out_valid, empty);
    end
  endtask

  task automatic test_async_reset();
    setup_inflight();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (count !== 8'd0 || out_valid !== 1'b0 || empty !== 1'b1 || mem_ren !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL arst_state: count %0d ov %b empty %b ren %b rdy %b, want 0 0 1 0 0",
                         count, out_valid, empty, mem_ren, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || empty !== 1'b1 || count !== 8'd0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL arst_after: ov %b empty %b count %0d rdy %b, want 0 1 0 1",
                         out_valid, empty, count, in_ready);
    end
    // FIFO still works from the reset pointers
    push(8'h5C);
    pop(8'h5C);
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
